// File: rtl/data_mem_bus.sv
// data_mem_bus: data-side memory decode for the core: byte-lane RAM, UART TX window, unmapped space.
// Loads are combinational; stores, FIFO pushes and STATUS read-clears land on the closing clock edge.
package Common;
    typedef enum logic [3:0] {
        MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_inst_type_t;
endpackage

module data_mem_bus import Common::*; #(
    parameter logic [31:0] RAM_BASE     = 32'h8000_0000,
    parameter int          RAM_WORDS    = 4096,
    parameter logic [31:0] UART_BASE    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           rst,
    input  mem_inst_type_t instType_i,
    input  logic [31:0]    dataAddress_i,
    input  logic [31:0]    writeData_i,
    input  logic           exception_i,
    output logic [31:0]    readData_o,
    output logic           uart_tx_o,
    output logic           uart_ovf_o
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * RAM_WORDS);
    localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic ram_hit, uart_hit, is_load, is_store, ram_we, push, pop, full, empty, status_rd, bdone;
    logic [AW-1:0] widx;
    logic [31:0] rword, status, wlanes;
    logic [3:0] be;
    logic [7:0] lb;
    logic [15:0] lh;
    logic [31:0] ram_q [RAM_WORDS];
    logic [7:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic ovf_q, ovf_d, tx_q, tx_d;
    tx_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;

    always_comb begin
        ram_hit   = ({1'b0, dataAddress_i} >= {1'b0, RAM_BASE}) && ({1'b0, dataAddress_i} < RAM_END);
        uart_hit  = dataAddress_i[31:3] == UART_BASE[31:3];
        is_load   = instType_i inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        is_store  = instType_i inside {MEM_SB, MEM_SH, MEM_SW};
        widx      = dataAddress_i[AW+1:2];
        full      = count_q == CW'(FIFO_DEPTH);
        empty     = count_q == '0;
        status    = {20'b0, 4'(count_q), 4'b0, ovf_q, state_q != IDLE, empty, full};
        rword     = ram_hit ? ram_q[widx] : (uart_hit && dataAddress_i[2]) ? status : 32'h0;
        lb        = rword[{dataAddress_i[1:0], 3'b000} +: 8];
        lh        = dataAddress_i[1] ? rword[31:16] : rword[15:0];
        readData_o = (instType_i == MEM_LW)  ? rword :
                     (instType_i == MEM_LB)  ? {{24{lb[7]}}, lb} :
                     (instType_i == MEM_LBU) ? {24'h0, lb} :
                     (instType_i == MEM_LH)  ? {{16{lh[15]}}, lh} :
                     (instType_i == MEM_LHU) ? {16'h0, lh} : 32'h0;
        be        = (instType_i == MEM_SW) ? 4'hF :
                    (instType_i == MEM_SH) ? (dataAddress_i[1] ? 4'hC : 4'h3) :
                    4'b0001 << dataAddress_i[1:0];
        wlanes    = (instType_i == MEM_SW) ? writeData_i :
                    (instType_i == MEM_SH) ? {2{writeData_i[15:0]}} : {4{writeData_i[7:0]}};
        ram_we    = is_store && !exception_i && ram_hit;
        push      = is_store && !exception_i && uart_hit && !dataAddress_i[2];
        status_rd = is_load && !exception_i && uart_hit && dataAddress_i[2];
        pop       = (state_q == IDLE) && !empty;
        wr_ptr_d  = wr_ptr_q + PW'(push && !full);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push && !full) - CW'(pop);
        // A dropped push outranks a same-cycle STATUS read-clear.
        ovf_d     = (push && full) || (ovf_q && !status_rd);
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        bdone   = baud_q == '0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    state_d = START;
                    shift_d = fifo_q[rd_ptr_q];
                    baud_d  = BMAX;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                baud_d = bdone ? BMAX : baud_q - 1'b1;
                if (bdone) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                baud_d = bdone ? BMAX : baud_q - 1'b1;
                if (bdone && bit_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else if (bdone) begin
                    bit_d   = bit_q + 1'b1;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            STOP: begin
                baud_d = bdone ? '0 : baud_q - 1'b1;
                if (bdone) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage arrays carry no reset: RAM keeps its contents, FIFO slots are dead once count clears.
    always_ff @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram_q[widx][8*i +: 8] <= wlanes[8*i +: 8];
        if (push && !full) fifo_q[wr_ptr_q] <= writeData_i[7:0];
    end

    assign uart_tx_o  = tx_q;
    assign uart_ovf_o = ovf_q;
endmodule
